// File: rtl/ocr_pkg.sv
// Shared encodings and default widths for the overcurrent trip stage.
package ocr_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int CNT_W_DEF  = 16;
    localparam int TRIP_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_TIMING  = 2'b01,
        ST_TRIPPED = 2'b10
    } ocr_state_t;

endpackage

// File: rtl/ocr_delay_counter.sv
// Saturating definite-time delay counter with clear, enable and terminal compare.
module ocr_delay_counter
    import ocr_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] trip_delay,
    output logic             terminal
);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_inc;

    assign count_inc = (&count) ? count : count + 1'b1;
    // Compared against the post-increment value so the FSM trips on the sample that reaches the delay.
    assign terminal  = (count_inc >= trip_delay);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count_inc;
        end
    end

endmodule

// File: rtl/overcurrent_trip_fsm.sv
// Overcurrent protection decision FSM: definite-time and instantaneous trip, latched until reset.
module overcurrent_trip_fsm
    import ocr_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int HYST    = 64,
    parameter bit INST_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_valid,
    input  logic [DATA_W-1:0]     current_in,
    input  logic [DATA_W-1:0]     pickup_threshold,
    input  logic [DATA_W-1:0]     inst_threshold,
    input  logic [CNT_W-1:0]      trip_delay,
    input  logic                  trip_reset,
    output logic                  pickup_flag,
    output logic                  trip_out,
    output logic [1:0]            fsm_state,
    output logic [TRIP_CNT_W-1:0] trip_count
);

    localparam logic [DATA_W:0] HYST_X = (DATA_W+1)'(HYST);

    ocr_state_t      state, state_next;
    logic [DATA_W:0] pickup_x, dropout;
    logic            inst_hit, over_pickup, below_dropout;
    logic            cnt_clr, cnt_en, cnt_term;

    assign pickup_x      = {1'b0, pickup_threshold};
    assign dropout       = (pickup_x >= HYST_X) ? pickup_x - HYST_X : '0;
    assign below_dropout = ({1'b0, current_in} < dropout);
    assign over_pickup   = (current_in >= pickup_threshold);
    assign inst_hit      = INST_EN && (current_in >= inst_threshold);

    ocr_delay_counter #(.CNT_W(CNT_W)) u_delay (
        .clk        (clk),
        .reset      (reset),
        .clear      (cnt_clr),
        .enable     (cnt_en),
        .trip_delay (trip_delay),
        .terminal   (cnt_term)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        if (sample_valid) begin
            case (state)
                ST_IDLE: begin
                    if (inst_hit || (over_pickup && trip_delay == '0)) begin
                        state_next = ST_TRIPPED;
                    end else if (over_pickup) begin
                        state_next = ST_TIMING;
                        cnt_en     = 1'b1;
                    end
                end
                ST_TIMING: begin
                    if (inst_hit) begin
                        state_next = ST_TRIPPED;
                    end else if (below_dropout) begin
                        state_next = ST_IDLE;
                    end else begin
                        cnt_en = 1'b1;
                        if (cnt_term) state_next = ST_TRIPPED;
                    end
                end
                ST_TRIPPED: begin
                    // A simultaneous instantaneous fault keeps the breaker open.
                    if (trip_reset && below_dropout && !inst_hit) state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
            if (state_next != ST_TIMING) cnt_clr = 1'b1;
        end
    end

    always_comb begin
        pickup_flag = (state == ST_TIMING);
        trip_out    = (state == ST_TRIPPED);
        fsm_state   = state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trip_count <= '0;
        end else if (state != ST_TRIPPED && state_next == ST_TRIPPED && !(&trip_count)) begin
            trip_count <= trip_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_overcurrent_trip_fsm.sv
// Directed bench: two DUTs (instantaneous element on/off) checked every cycle against a behavioural model.
module tb_overcurrent_trip_fsm;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_valid = 1'b0;
    logic [15:0] current_in = '0;
    logic [15:0] pickup_threshold = 16'd1000;
    logic [15:0] inst_threshold = 16'd4000;
    logic [15:0] trip_delay = 16'd5;
    logic        trip_reset = 1'b0;

    logic       pf [2];
    logic       to [2];
    logic [1:0] st [2];
    logic [7:0] tc [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    overcurrent_trip_fsm #(.DATA_W(16), .CNT_W(16), .HYST(64), .INST_EN(1'b1)) u_dut (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .current_in(current_in),
        .pickup_threshold(pickup_threshold), .inst_threshold(inst_threshold),
        .trip_delay(trip_delay), .trip_reset(trip_reset),
        .pickup_flag(pf[0]), .trip_out(to[0]), .fsm_state(st[0]), .trip_count(tc[0]));

    overcurrent_trip_fsm #(.DATA_W(16), .CNT_W(16), .HYST(64), .INST_EN(1'b0)) u_dut_ni (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .current_in(current_in),
        .pickup_threshold(pickup_threshold), .inst_threshold(inst_threshold),
        .trip_delay(trip_delay), .trip_reset(trip_reset),
        .pickup_flag(pf[1]), .trip_out(to[1]), .fsm_state(st[1]), .trip_count(tc[1]));

    // Behavioural model: k=0 has the instantaneous element, k=1 does not.
    bit m_tim [2];
    bit m_trp [2];
    int m_cnt [2];
    int m_trips [2];
    bit mv_inst, mv_below, mv_over, mv_fire;
    int mv_drop;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                m_tim[k] = 0; m_trp[k] = 0; m_cnt[k] = 0; m_trips[k] = 0;
            end
        end else if (sample_valid) begin
            for (int k = 0; k < 2; k++) begin
                mv_drop  = (int'(pickup_threshold) > 64) ? int'(pickup_threshold) - 64 : 0;
                mv_inst  = (k == 0) && (current_in >= inst_threshold);
                mv_below = int'(current_in) < mv_drop;
                mv_over  = current_in >= pickup_threshold;
                mv_fire  = 0;
                if (m_trp[k]) begin
                    if (trip_reset && mv_below && !mv_inst) begin
                        m_trp[k] = 0; m_cnt[k] = 0;
                    end
                end else if (mv_inst) begin
                    mv_fire = 1;
                end else if (m_tim[k]) begin
                    if (mv_below) begin
                        m_tim[k] = 0; m_cnt[k] = 0;
                    end else begin
                        m_cnt[k] = (m_cnt[k] < 65535) ? m_cnt[k] + 1 : 65535;
                        if (m_cnt[k] >= int'(trip_delay)) mv_fire = 1;
                    end
                end else if (mv_over) begin
                    if (trip_delay == 0) mv_fire = 1;
                    else begin m_tim[k] = 1; m_cnt[k] = 1; end
                end
                if (mv_fire) begin
                    m_tim[k] = 0; m_trp[k] = 1; m_cnt[k] = 0;
                    if (m_trips[k] < 255) m_trips[k]++;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("model pickup_flag[%0d]", k), int'(pf[k]), int'(m_tim[k]));
                chk($sformatf("model trip_out[%0d]", k), int'(to[k]), int'(m_trp[k]));
                chk($sformatf("model fsm_state[%0d]", k), int'(st[k]), int'({m_trp[k], m_tim[k]}));
                chk($sformatf("model trip_count[%0d]", k), int'(tc[k]), m_trips[k]);
            end
        end
    end

    task automatic strobe(input int cur, input bit tr);
        @(negedge clk);
        sample_valid = 1'b1; current_in = 16'(cur); trip_reset = tr;
        @(negedge clk);
        sample_valid = 1'b0; trip_reset = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    initial begin
        gap(3);
        chk("reset pickup_flag", int'(pf[0]), 0);
        chk("reset trip_out", int'(to[0]), 0);
        chk("reset fsm_state", int'(st[0]), 0);
        chk("reset trip_count", int'(tc[0]), 0);
        reset = 1'b0;

        // 1) definite-time trip after 5 strobes
        strobe(1200, 0);
        chk("t1 pickup after strobe1", int'(pf[0]), 1);
        repeat (3) strobe(1200, 0);
        chk("t1 no trip at strobe4", int'(to[0]), 0);
        strobe(1200, 0);
        chk("t1 trip at strobe5", int'(to[0]), 1);
        chk("t1 trip_count", int'(tc[0]), 1);

        // 4) reset ignored while current above dropout, honoured below
        strobe(1200, 1);
        chk("t4 trip held in fault", int'(to[0]), 1);
        strobe(500, 1);
        chk("t4 trip released", int'(to[0]), 0);
        chk("t4 state idle", int'(st[0]), 0);
        chk("t4 trip_count kept", int'(tc[0]), 1);

        // 2) hysteresis band then dropout, counter restarts
        do_reset();
        repeat (3) strobe(1200, 0);
        strobe(950, 0);
        chk("t2 band keeps timing", int'(pf[0]), 1);
        strobe(900, 0);
        chk("t2 dropout idle", int'(st[0]), 0);
        repeat (4) strobe(1200, 0);
        chk("t2 counter restarted", int'(to[0]), 0);
        strobe(1200, 0);
        chk("t2 trip after fresh 5", int'(to[0]), 1);

        // 3) instantaneous trip; INST_EN=0 instance goes definite-time
        do_reset();
        strobe(4100, 0);
        chk("t3 inst trip", int'(to[0]), 1);
        chk("t3 no-inst timing", int'(st[1]), 1);
        repeat (4) strobe(4100, 0);
        chk("t3 no-inst trips at 5", int'(to[1]), 1);

        // 5) zero delay at exactly pickup, then async reset mid-TIMING
        do_reset();
        trip_delay = 16'd0;
        strobe(1000, 0);
        chk("t5 immediate trip", int'(st[0]), 2);
        strobe(500, 1);
        trip_delay = 16'd5;
        strobe(1200, 0);
        chk("t5 timing before reset", int'(pf[0]), 1);
        @(negedge clk); #2 reset = 1'b1;
        #1;
        chk("t5 async pickup_flag", int'(pf[0]), 0);
        chk("t5 async fsm_state", int'(st[0]), 0);
        chk("t5 async trip_count", int'(tc[0]), 0);
        #1 reset = 1'b0;

        // dropout floors at zero: trip cannot be reset when pickup < HYST
        pickup_threshold = 16'd50; trip_delay = 16'd0;
        strobe(60, 0);
        strobe(0, 1);
        chk("floor dropout holds trip", int'(to[0]), 1);
        pickup_threshold = 16'd1000; trip_delay = 16'd5;

        // 6) strobe gaps then saturation
        do_reset();
        repeat (2) strobe(1200, 0);
        gap(10);
        chk("t6 gap holds timing", int'(pf[0]), 1);
        repeat (2) strobe(1200, 0);
        chk("t6 gap no advance", int'(to[0]), 0);
        strobe(1200, 0);
        chk("t6 trip after gap", int'(to[0]), 1);
        do_reset();
        trip_delay = 16'd0;
        for (int i = 0; i < 256; i++) begin
            strobe(1000, 0);
            strobe(500, 1);
        end
        chk("t6 saturate", int'(tc[0]), 255);
        chk("t6 saturate no-inst", int'(tc[1]), 255);

        gap(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
